// File: rtl/contador_pkg.sv
// Shared types and the operation decoder for the parametrised up/down counter.
// Optional saturation (macro CONTADOR_SAT_EN) is handled in the top and next-state files.
package contador_pkg;

  localparam int unsigned CNT_OP_W = 2;

  // Direction flag encoding held in the DIR register
  localparam logic CNT_DIR_UP   = 1'b1;
  localparam logic CNT_DIR_DOWN = 1'b0;

  typedef enum logic [CNT_OP_W-1:0] {
    CNT_HOLD,
    CNT_UP,
    CNT_DOWN,
    CNT_LOAD
  } cnt_op_t;

  // Priority decoder: reset suppresses every operation, then load, then a qualified step
  function automatic cnt_op_t cnt_decode(input logic mr, input logic pl_n,
                                         input logic step, input logic up);
    cnt_op_t op;
    op = CNT_HOLD;
    if (mr) begin
      op = CNT_HOLD;
    end else if (!pl_n) begin
      op = CNT_LOAD;
    end else if (step) begin
      op = up ? CNT_UP : CNT_DOWN;
    end
    return op;
  endfunction

endpackage

// File: rtl/contador_next.sv
// Combinational next-count and carry-out logic for one counter stage.
module contador_next
  import contador_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  cnt_op_t          op,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] max_val,
  input  logic             sat,
  output logic [WIDTH-1:0] q_next,
  output logic             co
);

  logic at_max;
  logic at_zero;

  assign at_max  = (q >= max_val);
  assign at_zero = (q == '0);

  // Next value per operation; a saturated stage holds and emits no carry
  always_comb begin
    q_next = q;
    co     = 1'b0;
    case (op)
      CNT_LOAD: q_next = p;
      CNT_UP: begin
        if (at_max) begin
          if (!sat) begin
            q_next = '0;
            co     = 1'b1;
          end
        end else begin
          q_next = q + WIDTH'(1);
        end
      end
      CNT_DOWN: begin
        if (at_zero) begin
          if (!sat) begin
            q_next = max_val;
            co     = 1'b1;
          end
        end else begin
          q_next = q - WIDTH'(1);
        end
      end
      default: q_next = q;
    endcase
  end

endmodule

// File: rtl/contador_updown_param.sv
// Parametrised synchronous up/down counter with load, enable and carry cascade.
// Define CONTADOR_SAT_EN to add the sat input (saturate instead of wrap).
module contador_updown_param
  import contador_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MAX_VAL = (1 << WIDTH) - 1,
  parameter int unsigned RST_VAL = 0
) (
  input  logic             cp,
  input  logic             mr,
  input  logic             pl,
  input  logic [WIDTH-1:0] p,
  input  logic             cen,
  input  logic             ci,
  input  logic             up,
  input  logic             dn,
`ifdef CONTADOR_SAT_EN
  input  logic             sat,
`endif
  output logic [WIDTH-1:0] q,
  output logic             dir,
  output logic             tcu,
  output logic             tcd,
  output logic             co
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RST_VAL);

  logic             step_c;
  logic             sat_c;
  logic             dir_next;
  logic [WIDTH-1:0] q_next;
  cnt_op_t          op;

`ifdef CONTADOR_SAT_EN
  assign sat_c = sat;
`else
  assign sat_c = 1'b0;
`endif

  assign step_c = cen & ci & (up ^ dn);
  assign op     = cnt_decode(mr, pl, step_c, up);

  contador_next #(
    .WIDTH (WIDTH)
  ) u_next (
    .op      (op),
    .q       (q),
    .p       (p),
    .max_val (MAX_Q),
    .sat     (sat_c),
    .q_next  (q_next),
    .co      (co)
  );

  // Direction follows the last step taken; load and hold keep it
  always_comb begin
    dir_next = dir;
    case (op)
      CNT_UP:   dir_next = CNT_DIR_UP;
      CNT_DOWN: dir_next = CNT_DIR_DOWN;
      default:  dir_next = dir;
    endcase
  end

  // Count/direction registers; terminal flags registered from the same next values
  always_ff @(posedge cp) begin
    if (mr) begin
      q   <= RST_Q;
      dir <= CNT_DIR_UP;
      tcu <= ~(RST_Q >= MAX_Q);
      tcd <= 1'b1;
    end else begin
      q   <= q_next;
      dir <= dir_next;
      tcu <= ~((q_next >= MAX_Q) & (dir_next == CNT_DIR_UP));
      tcd <= ~((q_next == '0) & (dir_next == CNT_DIR_DOWN));
    end
  end

endmodule

// File: tb/tb_contador_updown_param.sv
// Self-checking bench for contador_updown_param (modulus-10 stage plus a two-stage cascade).
module tb_contador_updown_param;

  localparam int unsigned W   = 4;
  localparam int unsigned MAX = 9;

  logic         cp;
  logic         mr, pl, cen, ci, up, dn;
  logic [W-1:0] p;
  logic [W-1:0] q;
  logic         dir, tcu, tcd, co;
`ifdef CONTADOR_SAT_EN
  logic         sat;
`endif

  logic         c_mr;
  logic [W-1:0] q0, q1;
  logic         dir0, dir1, tcu0, tcu1, tcd0, tcd1, co0, co1;

  int unsigned  checks;
  int unsigned  failures;

  int unsigned  mq;
  logic         mdir;
  logic         msat;

  contador_updown_param #(.WIDTH(W), .MAX_VAL(MAX), .RST_VAL(0)) dut (
    .cp(cp), .mr(mr), .pl(pl), .p(p), .cen(cen), .ci(ci), .up(up), .dn(dn),
`ifdef CONTADOR_SAT_EN
    .sat(sat),
`endif
    .q(q), .dir(dir), .tcu(tcu), .tcd(tcd), .co(co)
  );

  contador_updown_param #(.WIDTH(W)) u_c0 (
    .cp(cp), .mr(c_mr), .pl(1'b1), .p(4'd0), .cen(1'b1), .ci(1'b1), .up(1'b1), .dn(1'b0),
`ifdef CONTADOR_SAT_EN
    .sat(1'b0),
`endif
    .q(q0), .dir(dir0), .tcu(tcu0), .tcd(tcd0), .co(co0)
  );

  contador_updown_param #(.WIDTH(W)) u_c1 (
    .cp(cp), .mr(c_mr), .pl(1'b1), .p(4'd0), .cen(1'b1), .ci(co0), .up(1'b1), .dn(1'b0),
`ifdef CONTADOR_SAT_EN
    .sat(1'b0),
`endif
    .q(q1), .dir(dir1), .tcu(tcu1), .tcd(tcd1), .co(co1)
  );

  initial begin
    cp = 1'b0;
    forever #5 cp = ~cp;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic i_mr, input logic i_pl, input int unsigned i_p,
                        input logic i_cen, input logic i_ci, input logic i_up, input logic i_dn);
    mr  = i_mr;
    pl  = i_pl;
    p   = W'(i_p);
    cen = i_cen;
    ci  = i_ci;
    up  = i_up;
    dn  = i_dn;
  endtask

  // One clock: check carry lookahead, advance the reference, check registered outputs
  task automatic tick(input string tag);
    logic step;
    logic exp_co;
    #1;
    step   = cen & ci & (up ^ dn);
    exp_co = !mr && pl && step && !msat && ((up && mq >= MAX) || (dn && mq == 0));
    chk({tag, ".co"}, 32'(co), 32'(exp_co));
    if (mr) begin
      mq   = 0;
      mdir = 1'b1;
    end else if (!pl) begin
      mq = int'(p);
    end else if (step && up) begin
      mdir = 1'b1;
      if (!(msat && mq >= MAX))
        mq = (mq > MAX) ? 0 : (mq + 1) % (MAX + 1);
    end else if (step && dn) begin
      mdir = 1'b0;
      if (!(msat && mq == 0))
        mq = (mq > MAX) ? mq - 1 : (mq + MAX) % (MAX + 1);
    end
    @(posedge cp);
    #1;
    chk({tag, ".q"},   32'(q),   32'(mq));
    chk({tag, ".dir"}, 32'(dir), 32'(mdir));
    chk({tag, ".tcu"}, 32'(tcu), 32'(!(mq >= MAX && mdir)));
    chk({tag, ".tcd"}, 32'(tcd), 32'(!(mq == 0 && !mdir)));
  endtask

  initial begin
    int unsigned co1_pulses;
    checks   = 0;
    failures = 0;
    mq       = 0;
    mdir     = 1'b1;
    msat     = 1'b0;
    c_mr     = 1'b1;
`ifdef CONTADOR_SAT_EN
    sat = 1'b0;
`endif

    // Reset
    set_in(1, 1, 0, 0, 0, 0, 0);  tick("reset");

    // Wrap up through MAX_VAL
    set_in(0, 0, 8, 0, 0, 0, 0);  tick("wrapup_load");
    set_in(0, 1, 0, 1, 1, 1, 0);
    for (int i = 0; i < 3; i++) tick("wrapup");

    // Wrap down through zero
    set_in(0, 0, 1, 0, 0, 0, 0);  tick("wrapdn_load");
    set_in(0, 1, 0, 1, 1, 0, 1);
    for (int i = 0; i < 3; i++) tick("wrapdn");

    // Priority: reset over load over step
    set_in(0, 0, 5, 0, 0, 0, 0);  tick("prio_load");
    set_in(1, 0, 3, 1, 1, 1, 0);  tick("prio_mr");
    set_in(0, 0, 3, 1, 1, 1, 0);  tick("prio_pl");

    // Hold cases and out-of-range load
    set_in(0, 0, 4, 0, 0, 0, 0);  tick("hold_load");
    set_in(0, 1, 0, 1, 1, 1, 1);  tick("hold_both");
    set_in(0, 1, 0, 0, 1, 1, 0);  tick("hold_cen");
    set_in(0, 1, 0, 1, 0, 0, 1);  tick("hold_ci");
    set_in(0, 0, 15, 0, 0, 0, 0); tick("big_load");
    set_in(0, 1, 0, 1, 1, 1, 0);  tick("big_up");

`ifdef CONTADOR_SAT_EN
    // Saturation at the top
    sat = 1'b1; msat = 1'b1;
    set_in(0, 0, 9, 0, 0, 0, 0);  tick("sat_load");
    set_in(0, 1, 0, 1, 1, 1, 0);  tick("sat_up");
    set_in(0, 1, 0, 1, 1, 0, 1);  tick("sat_dn");
    sat = 1'b0; msat = 1'b0;
`endif

    // Randomized traffic against the reference
    for (int i = 0; i < 400; i++) begin
      set_in(($urandom % 25) == 0, ($urandom % 8) != 0, $urandom % 16,
             ($urandom % 4) != 0, ($urandom % 5) != 0, 1'($urandom), 1'($urandom));
`ifdef CONTADOR_SAT_EN
      sat  = 1'($urandom);
      msat = sat;
`endif
      tick("rand");
    end
`ifdef CONTADOR_SAT_EN
    sat = 1'b0; msat = 1'b0;
`endif

    // Cascade of two 4-bit stages: 256 up steps wrap the 8-bit value once
    @(posedge cp);
    #1;
    c_mr = 1'b0;
    chk("casc_reset", 32'({q1, q0}), 32'd0);
    co1_pulses = 0;
    for (int k = 0; k < 256; k++) begin
      #1;
      chk("casc_co1", 32'(co1), 32'(k == 255));
      if (co1) co1_pulses++;
      @(posedge cp);
      #1;
      chk("casc_q", 32'({q1, q0}), 32'((k + 1) % 256));
    end
    chk("casc_pulses", 32'(co1_pulses), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
